// File: rtl/serial_adder.sv
// serial_adder: bit-serial ripple adder (one full-adder cell + carry FF), LSB first,
// start/busy/done handshake. Optional subtract mode: define SERIAL_ADDER_SUB_MODE_EN.
module serial_adder #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
`ifdef SERIAL_ADDER_SUB_MODE_EN
   input  logic             Sub,
`endif
   output logic [WIDTH-1:0] S,
   output logic             Co,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           r_state;
   state_t           w_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_s;
   logic             r_c;
   logic             r_co;
   logic [CW-1:0]    r_cnt;
   logic             w_accept;
   logic             w_last;
   logic             w_sub;
   logic             w_cin0;
   logic             w_b0;
   logic             w_sum;
   logic             w_cout;

`ifdef SERIAL_ADDER_SUB_MODE_EN
   logic r_sub;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        r_sub <= 1'b0;
      else if (w_accept) r_sub <= Sub;
   end

   // Subtract as A + ~B + 1: invert B bits on the fly and seed the carry with 1.
   assign w_sub  = r_sub;
   assign w_cin0 = Sub;
`else
   assign w_sub  = 1'b0;
   assign w_cin0 = 1'b0;
`endif

   assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_last   = (r_cnt == CW'(WIDTH - 1));
   assign w_b0     = r_b[0] ^ w_sub;
   assign w_sum    = r_a[0] ^ w_b0 ^ r_c;
   assign w_cout   = (r_a[0] & w_b0) | (r_a[0] & r_c) | (w_b0 & r_c);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (start) w_next = RUN;
         end
         RUN: begin
            busy = 1'b1;
            if (w_last) w_next = DONE;
         end
         DONE: begin
            done   = 1'b1;
            w_next = start ? RUN : IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a   <= '0;
         r_b   <= '0;
         r_s   <= '0;
         r_c   <= 1'b0;
         r_co  <= 1'b0;
         r_cnt <= '0;
      end else if (w_accept) begin
         r_a   <= A;
         r_b   <= B;
         r_c   <= w_cin0;
         r_cnt <= '0;
      end else if (r_state == RUN) begin
         r_s   <= {w_sum, r_s[WIDTH-1:1]};
         r_a   <= r_a >> 1;
         r_b   <= r_b >> 1;
         r_c   <= w_cout;
         r_cnt <= r_cnt + 1'b1;
         // Co is only published on the final bit so it holds the previous result until then.
         if (w_last) r_co <= w_cout ^ w_sub;
      end
   end

   assign S  = r_s;
   assign Co = r_co;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: table vectors, random sweep, round-trip and
// multi-cycle corner sequences; expected {Co,S} values flow through a scoreboard queue.
module tb_serial_adder;

   localparam int unsigned W = 8;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic         Sub;
   logic [W-1:0] S;
   logic         Co;
   logic         busy;
   logic         done;

   int errors = 0;
   int checks = 0;
   logic [W:0] exp_q[$];

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] s;
      logic         co;
   } vec_t;

   vec_t vecs[6];

   serial_adder #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .A     (A),
      .B     (B),
`ifdef SERIAL_ADDER_SUB_MODE_EN
      .Sub   (Sub),
`endif
      .S     (S),
      .Co    (Co),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Advance to the next falling edge; any done pulse seen there is scored against the queue.
   task automatic tick();
      logic [W:0] e;
      @(negedge clk);
      if (rst_n && done) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: got Co=%0d S=%0d expected no done", Co, S);
         end else begin
            e = exp_q.pop_front();
            if ({Co, S} !== e) begin
               errors++;
               $display("FAIL result: got Co=%0d S=%0d expected Co=%0d S=%0d",
                        Co, S, e[W], e[W-1:0]);
            end
         end
      end
   endtask

   function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic sub);
      logic [W:0] r;
      if (sub) begin
         r[W-1:0] = a - b;
         r[W]     = (a < b);
      end else begin
         r = {1'b0, a} + {1'b0, b};
      end
      return r;
   endfunction

   task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
      A     = a;
      B     = b;
      Sub   = sub;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input logic [W:0] exp);
      int nb;
      int first;
      tick();
      exp_q.push_back(exp);
      drive_start(a, b, sub);
      nb    = 0;
      first = 0;
      for (int i = 1; i <= int'(W) + 1; i++) begin
         tick();
         if (busy) nb++;
         if (done && first == 0) first = i;
      end
      chk("busy_cycles", nb, W);
      chk("done_latency", first, W + 1);
      tick();
      chk("done_single_pulse", done, 0);
   endtask

   initial begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] d;
      logic [W:0]   sum;
      int           n;
      logic         got;

      vecs[0] = '{a: 8'd3,   b: 8'd5,   s: 8'd8,   co: 1'b0};
      vecs[1] = '{a: 8'd255, b: 8'd1,   s: 8'd0,   co: 1'b1};
      vecs[2] = '{a: 8'd0,   b: 8'd0,   s: 8'd0,   co: 1'b0};
      vecs[3] = '{a: 8'd255, b: 8'd255, s: 8'd254, co: 1'b1};
      vecs[4] = '{a: 8'd128, b: 8'd128, s: 8'd0,   co: 1'b1};
      vecs[5] = '{a: 8'd170, b: 8'd85,  s: 8'd255, co: 1'b0};

      rst_n = 1'b0;
      start = 1'b0;
      A     = '0;
      B     = '0;
      Sub   = 1'b0;
      #12;
      chk("reset_S", S, 0);
      chk("reset_Co", Co, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, 1'b0, {vecs[i].co, vecs[i].s});

      tick();
      tick();
      chk("hold_S_idle", S, vecs[5].s);
      chk("hold_Co_idle", Co, vecs[5].co);

      // start re-asserted during RUN must be ignored
      tick();
      exp_q.push_back({1'b0, 8'd150});
      drive_start(8'd100, 8'd50, 1'b0);
      n = 0;
      repeat (3) begin
         tick();
         n++;
      end
      drive_start(8'd1, 8'd1, 1'b0);
      got = 1'b0;
      for (int i = 0; i < 3 * int'(W) && !got; i++) begin
         tick();
         n++;
         if (done) got = 1'b1;
      end
      chk("ignore_start_done_seen", got, 1);
      chk("ignore_start_latency", n, W + 1);

      // back-to-back: start held in DONE restarts with no idle gap
      exp_q.push_back({1'b0, 8'd16});
      drive_start(8'd7, 8'd9, 1'b0);
      tick();
      chk("b2b_busy_immediate", busy, 1);
      chk("b2b_done_low", done, 0);
      n   = 1;
      got = 1'b0;
      for (int i = 0; i < 3 * int'(W) && !got; i++) begin
         tick();
         n++;
         if (done) got = 1'b1;
      end
      chk("b2b_done_seen", got, 1);
      chk("b2b_latency", n, W + 1);
      repeat (3) tick();
      chk("b2b_hold_S", S, 16);
      chk("b2b_hold_busy", busy, 0);

      // asynchronous reset in the middle of RUN
      tick();
      drive_start(8'd200, 8'd100, 1'b0);
      repeat (4) tick();
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_S", S, 0);
      chk("midrst_Co", Co, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < int'(W) + 4; i++) begin
         tick();
         chk("midrst_no_done", done, 0);
      end
      chk("midrst_idle_busy", busy, 0);
      chk("midrst_queue_empty", exp_q.size(), 0);

      for (int i = 0; i < 1000; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         run_op(a, b, 1'b0, model(a, b, 1'b0));
      end

      // round trip: D = A - B from a subtractor, the adder must give back A
      for (int i = 0; i < 50; i++) begin
         a   = W'($urandom);
         b   = W'($urandom);
         d   = a - b;
         sum = {1'b0, d} + {1'b0, b};
         run_op(d, b, 1'b0, {sum[W], a});
      end

`ifdef SERIAL_ADDER_SUB_MODE_EN
      run_op(8'd5, 8'd3, 1'b1, {1'b0, 8'd2});
      run_op(8'd3, 8'd5, 1'b1, {1'b1, 8'd254});
      run_op(8'd3, 8'd5, 1'b0, {1'b0, 8'd8});
      for (int i = 0; i < 100; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         run_op(a, b, 1'b1, model(a, b, 1'b1));
      end
`endif

      repeat (3) tick();
      chk("final_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
- Bit-serial ripple adder. It is the inverse operation of the half_subtractor: it reconstructs A = D + B, one bit per clock, LSB first.
- It uses one full-adder cell and a carry flip-flop, with start/busy/done handshaking.
- It sits beside the combinational subtractor for area-constrained arithmetic and round-trip checks (D, B from the subtractor go in; A comes out).

Parameters:
- WIDTH, 8, operand and result width in bits (>= 2).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled on rising clk.
- A  input  WIDTH  first operand; captured when start is accepted.
- B  input  WIDTH  second operand; captured when start is accepted.
- S  output  WIDTH  sum; valid while done=1 and held until the next accepted start.
- Co  output  1  carry out of the MSB; same validity as S.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous and active-low. All state is cleared immediately on rst_n=0, independent of clk.
- Reset values: S=0, Co=0, busy=0, done=0, state=IDLE, internal carry=0, bit counter=0, operand shift registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k: capture A and B into shift registers, clear carry and counter, go to RUN. busy=1 after edge k.
  - start=0: stay in IDLE.
- RUN, at each edge:
  - Sum bit = a0 ^ b0 ^ c, where a0/b0 are the shift-register LSBs.
  - Next carry = majority(a0, b0, c).
  - The sum bit shifts into S from the MSB side.
  - Operand registers shift right.
  - Counter increments.
- RUN exit: the edge that processes bit WIDTH-1 (edge k+WIDTH) moves to DONE. S and Co are final after that edge.
- start is ignored in RUN; captured operands cannot be changed mid-operation.
- DONE: lasts exactly one cycle, with done=1 and busy=0.
  - Next edge with start=1: accept new operands and go to RUN (back-to-back, no idle gap).
  - Otherwise go to IDLE.
- Latency: start accepted at edge k -> done high in the cycle after edge k+WIDTH. Throughput is one result per WIDTH+1 cycles.
- Width rules:
  - Result is modulo 2^WIDTH.
  - Co = bit WIDTH of the true sum.
  - {Co,S} = A + B exactly.
- Output hold: S and Co keep their last result through IDLE. They change only while a new RUN shifts.
  - S bits are visibly partial during RUN.
  - Consumers sample only when done=1.
- Reset mid-operation: outputs return to reset values; no done pulse. A fresh start is required after rst_n deasserts.
- Counter width: $clog2(WIDTH)+1 bits; must not wrap before reaching WIDTH.

Optional Feature:
Macro: SERIAL_ADDER_SUB_MODE_EN
- Defined:
  - Adds input port Sub (1 bit), captured with the operands on an accepted start.
  - Sub=1 computes A - B: B bits are inverted as they shift, and the initial carry is 1. Co then reports borrow: Co = ~final_carry (Bo convention, 1 when A < B).
  - Sub=0 behaves exactly as the base adder.
- Undefined: no Sub port; adder only. Port list and timing are otherwise identical.

Test Plan:
- Reset then A=3, B=5, start pulse, WIDTH=8 -> busy high 8 cycles; done pulses once 9 cycles after start edge; S=8, Co=0.
- A=255, B=1 -> S=0, Co=1. A=0, B=0 -> S=0, Co=0, done still pulses.
- A=100, B=50 started; start re-asserted with A=1, B=1 at RUN cycle 3 -> ignored; result S=150. Then start held high in DONE with A=7, B=9 -> next RUN begins immediately; S=16 at next done.
- Start A=200, B=100; assert rst_n=0 asynchronously mid-cycle at RUN cycle 4 -> S=0, Co=0, busy=0, done=0 immediately; no done pulse after release.
- Random sweep of 1000 operand pairs vs. model {Co,S}=A+B. Round-trip: feed half_subtractor-style (D,B) pairs per bit -> recovered A matches.
- SERIAL_ADDER_SUB_MODE_EN defined:
  - Sub=1, A=5, B=3 -> S=2, Co=0.
  - A=3, B=5 -> S=254, Co=1.
  - Sub=0, A=3, B=5 -> S=8, Co=0.
